// File: rtl/tv80_bus_pkg.sv
// Shared types for the tv80 bus bridge.
// Optional trace counters are enabled with TV80_BUS_TRACE_EN.
package tv80_bus_pkg;

  localparam int WAIT_W = 3;

  typedef enum logic [2:0] {
    CYC_NONE,
    CYC_INTACK,
    CYC_REFRESH,
    CYC_MRD,
    CYC_MWR,
    CYC_IORD,
    CYC_IOWR
  } bus_cyc_t;

  typedef enum logic [2:0] {
    IDLE,
    WAITST,
    ISSUE,
    CAPTURE,
    HOLD
  } bridge_state_t;

  function automatic logic cyc_is_read(
    input bus_cyc_t c
  );
    return (c == CYC_MRD) || (c == CYC_IORD);
  endfunction

  function automatic logic cyc_is_io(
    input bus_cyc_t c
  );
    return (c == CYC_IORD) || (c == CYC_IOWR);
  endfunction

  function automatic logic cyc_is_mem(
    input bus_cyc_t c
  );
    return (c == CYC_MRD) || (c == CYC_MWR);
  endfunction

endpackage

// File: rtl/tv80_bus_classify.sv
// Combinational decode of the tv80 control strobes into a bus cycle type.
// First match wins: intack, refresh, mem rd/wr, io rd/wr.
module tv80_bus_classify
  import tv80_bus_pkg::*;
(
  input  logic     mreq_n,
  input  logic     iorq_n,
  input  logic     rd_n,
  input  logic     wr_n,
  input  logic     m1_n,
  input  logic     rfsh_n,
  output bus_cyc_t cyc
);

  always_comb begin
    cyc = CYC_NONE;
    if (!m1_n && !iorq_n) begin
      cyc = CYC_INTACK;
    end else if (!rfsh_n && !mreq_n) begin
      cyc = CYC_REFRESH;
    end else if (!mreq_n && !rd_n) begin
      cyc = CYC_MRD;
    end else if (!mreq_n && !wr_n) begin
      cyc = CYC_MWR;
    end else if (!iorq_n && !rd_n) begin
      cyc = CYC_IORD;
    end else if (!iorq_n && !wr_n) begin
      cyc = CYC_IOWR;
    end
  end

endmodule

// File: rtl/tv80_bus_bridge.sv
// tv80 CPU bus to synchronous memory/IO bridge with wait-state insertion.
// Define TV80_BUS_TRACE_EN to add fetch_count / wr_count outputs.
module tv80_bus_bridge
  import tv80_bus_pkg::*;
#(
  parameter int         MEM_WAIT   = 0,
  parameter int         IO_WAIT    = 1,
  parameter logic [7:0] INT_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_rfsh_n,
  output logic        cpu_wait_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_we,
  output logic        io_re,
  input  logic [7:0]  io_rdata
`ifdef TV80_BUS_TRACE_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] wr_count
`endif
);

  localparam logic [WAIT_W-1:0] MEM_W = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] IO_W  = WAIT_W'(IO_WAIT);

  bridge_state_t     state_q, state_d;
  bus_cyc_t          cyc_q, cyc_d;
  bus_cyc_t          cyc_in;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_in;
  logic [7:0]        cpu_di_q, cpu_di_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        io_addr_q, io_addr_d;
  logic [7:0]        io_wdata_q, io_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              io_we_q, io_we_d;
  logic              io_re_q, io_re_d;
  logic              active;
  logic              issue;

  tv80_bus_classify u_classify (
    .mreq_n (cpu_mreq_n),
    .iorq_n (cpu_iorq_n),
    .rd_n   (cpu_rd_n),
    .wr_n   (cpu_wr_n),
    .m1_n   (cpu_m1_n),
    .rfsh_n (cpu_rfsh_n),
    .cyc    (cyc_in)
  );

  always_comb begin
    wait_in = '0;
    if (cyc_is_mem(cyc_in)) begin
      wait_in = MEM_W;
    end else if (cyc_is_io(cyc_in)) begin
      wait_in = IO_W;
    end
  end

  // The cycle stays live only while its own strobe pair is still low.
  always_comb begin
    active = 1'b0;
    case (cyc_q)
      CYC_INTACK: active = !cpu_m1_n && !cpu_iorq_n;
      CYC_MRD:    active = !cpu_mreq_n && !cpu_rd_n;
      CYC_MWR:    active = !cpu_mreq_n && !cpu_wr_n;
      CYC_IORD:   active = !cpu_iorq_n && !cpu_rd_n;
      CYC_IOWR:   active = !cpu_iorq_n && !cpu_wr_n;
      default:    active = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    cnt_d       = cnt_q;
    cpu_di_d    = cpu_di_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    io_we_d     = 1'b0;
    io_re_d     = 1'b0;
    issue       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cyc_in != CYC_NONE) begin
          cyc_d = cyc_in;
          if (cyc_in == CYC_REFRESH) begin
            state_d = HOLD;
          end else if (wait_in != '0) begin
            cnt_d   = wait_in;
            state_d = WAITST;
          end else begin
            issue = 1'b1;
          end
        end
      end
      WAITST: begin
        if (!active) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q <= WAIT_W'(1)) begin
          cnt_d = '0;
          issue = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ISSUE: begin
        if (!active) begin
          state_d = IDLE;
        end else if (cyc_is_read(cyc_q)) begin
          state_d = CAPTURE;
        end else begin
          state_d = HOLD;
        end
      end
      CAPTURE: begin
        if (!active) begin
          state_d = IDLE;
        end else begin
          cpu_di_d = cyc_is_io(cyc_q) ? io_rdata : mem_rdata;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cpu_mreq_n && cpu_iorq_n) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobe flops are loaded here so they are high exactly in ISSUE.
    if (issue) begin
      state_d = ISSUE;
      unique case (1'b1)
        cyc_d == CYC_MRD: begin
          mem_addr_d = cpu_a;
          mem_re_d   = 1'b1;
        end
        cyc_d == CYC_MWR: begin
          mem_addr_d  = cpu_a;
          mem_wdata_d = cpu_do;
          mem_we_d    = 1'b1;
        end
        cyc_d == CYC_IORD: begin
          io_addr_d = cpu_a[7:0];
          io_re_d   = 1'b1;
        end
        cyc_d == CYC_IOWR: begin
          io_addr_d  = cpu_a[7:0];
          io_wdata_d = cpu_do;
          io_we_d    = 1'b1;
        end
        cyc_d == CYC_INTACK: begin
          cpu_di_d = INT_VECTOR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= CYC_NONE;
      cnt_q       <= '0;
      cpu_di_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_re_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      cpu_di_q    <= cpu_di_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      io_we_q     <= io_we_d;
      io_re_q     <= io_re_d;
    end
  end

  assign cpu_di     = cpu_di_q;
  assign cpu_wait_n = !((state_q == WAITST) && (cnt_q != '0));
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign io_addr    = io_addr_q;
  assign io_wdata   = io_wdata_q;
  assign io_we      = io_we_q;
  assign io_re      = io_re_q;

`ifdef TV80_BUS_TRACE_EN
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] wr_q, wr_d;

  always_comb begin
    fetch_d = fetch_q;
    wr_d    = wr_q;
    if (issue) begin
      if (cyc_d == CYC_MRD && !cpu_m1_n && fetch_q != '1) begin
        fetch_d = fetch_q + 32'd1;
      end
      if ((cyc_d == CYC_MWR || cyc_d == CYC_IOWR) && wr_q != '1) begin
        wr_d = wr_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q <= '0;
      wr_q    <= '0;
    end else begin
      fetch_q <= fetch_d;
      wr_q    <= wr_d;
    end
  end

  assign fetch_count = fetch_q;
  assign wr_count    = wr_q;
`endif

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// Scoreboard bench for tv80_bus_bridge: zero-wait and two-wait-state instances.
// Honours TV80_BUS_TRACE_EN for the optional counter ports.
module tb_tv80_bus_bridge;
  import tv80_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;

  logic [7:0]  d0_di, d0_mem_wdata, d0_io_addr, d0_io_wdata;
  logic [7:0]  d0_mem_rdata, d0_io_rdata;
  logic [15:0] d0_mem_addr;
  logic        d0_wait_n, d0_mem_we, d0_mem_re, d0_io_we, d0_io_re;

  logic [7:0]  w2_di, w2_mem_wdata, w2_io_addr, w2_io_wdata;
  logic [7:0]  w2_mem_rdata;
  logic [7:0]  w2_io_rdata;
  logic [15:0] w2_mem_addr;
  logic        w2_wait_n, w2_mem_we, w2_mem_re, w2_io_we, w2_io_re;

`ifdef TV80_BUS_TRACE_EN
  logic [31:0] d0_fetch, d0_wrc, w2_fetch, w2_wrc;
`endif

  assign w2_io_rdata = 8'h00;

  tv80_bus_bridge #(.MEM_WAIT(0), .IO_WAIT(1), .INT_VECTOR(8'hFF)) u_dut (
    .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_di(d0_di), .cpu_mreq_n(mreq_n), .cpu_iorq_n(iorq_n),
    .cpu_rd_n(rd_n), .cpu_wr_n(wr_n), .cpu_m1_n(m1_n),
    .cpu_rfsh_n(rfsh_n), .cpu_wait_n(d0_wait_n),
    .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata),
    .mem_we(d0_mem_we), .mem_re(d0_mem_re), .mem_rdata(d0_mem_rdata),
    .io_addr(d0_io_addr), .io_wdata(d0_io_wdata), .io_we(d0_io_we),
    .io_re(d0_io_re), .io_rdata(d0_io_rdata)
`ifdef TV80_BUS_TRACE_EN
    , .fetch_count(d0_fetch), .wr_count(d0_wrc)
`endif
  );

  tv80_bus_bridge #(.MEM_WAIT(2), .IO_WAIT(1), .INT_VECTOR(8'hFF)) u_w2 (
    .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_di(w2_di), .cpu_mreq_n(mreq_n), .cpu_iorq_n(iorq_n),
    .cpu_rd_n(rd_n), .cpu_wr_n(wr_n), .cpu_m1_n(m1_n),
    .cpu_rfsh_n(rfsh_n), .cpu_wait_n(w2_wait_n),
    .mem_addr(w2_mem_addr), .mem_wdata(w2_mem_wdata),
    .mem_we(w2_mem_we), .mem_re(w2_mem_re), .mem_rdata(w2_mem_rdata),
    .io_addr(w2_io_addr), .io_wdata(w2_io_wdata), .io_we(w2_io_we),
    .io_re(w2_io_re), .io_rdata(w2_io_rdata)
`ifdef TV80_BUS_TRACE_EN
    , .fetch_count(w2_fetch), .wr_count(w2_wrc)
`endif
  );

  // Synchronous memory / IO models
  logic [7:0] mem [0:65535];
  logic [7:0] iom [0:255];

  always @(posedge clk) begin
    if (d0_mem_we) mem[d0_mem_addr] <= d0_mem_wdata;
    if (d0_mem_re) d0_mem_rdata <= mem[d0_mem_addr];
    if (d0_io_we)  iom[d0_io_addr] <= d0_io_wdata;
    if (d0_io_re)  d0_io_rdata <= iom[d0_io_addr];
    if (w2_mem_re) w2_mem_rdata <= mem[w2_mem_addr];
  end

  int d0_re_n = 0, d0_we_n = 0, d0_ior_n = 0, d0_wait_lo = 0;
  int w2_re_n = 0, w2_wait_lo = 0;

  always @(posedge clk) begin
    d0_re_n    <= d0_re_n + int'(d0_mem_re);
    d0_we_n    <= d0_we_n + int'(d0_mem_we);
    d0_ior_n   <= d0_ior_n + int'(d0_io_re);
    d0_wait_lo <= d0_wait_lo + int'(!d0_wait_n);
    w2_re_n    <= w2_re_n + int'(w2_mem_re);
    w2_wait_lo <= w2_wait_lo + int'(!w2_wait_n);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind: 0 mem read, 1 mem write, 2 io read, 3 io write
  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          chk_di;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic [1:0] k, input logic [15:0] a,
                      input logic [7:0] d, input bit c);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d; e.chk_di = c;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    int          nstb;
    logic [1:0]  k;
    logic [15:0] oa;
    logic [7:0]  od;
    forever begin
      @(negedge clk);
      nstb = int'(d0_mem_re) + int'(d0_mem_we) + int'(d0_io_re) + int'(d0_io_we);
      if (nstb != 0) begin
        if (nstb > 1) check("strobe_onehot", nstb, 1);
        k  = d0_mem_re ? 2'd0 : d0_mem_we ? 2'd1 : d0_io_re ? 2'd2 : 2'd3;
        oa = (k < 2) ? d0_mem_addr : {8'h00, d0_io_addr};
        od = (k == 1) ? d0_mem_wdata : d0_io_wdata;
        if (sb.size() == 0) begin
          check("unexpected_strobe", nstb, 0);
        end else begin
          e = sb.pop_front();
          check("sb_kind", k, e.kind);
          check("sb_addr", oa, e.addr);
          if (k == 1 || k == 3) check("sb_wdata", od, e.data);
          if ((k == 0 || k == 2) && e.chk_di) begin
            repeat (2) @(negedge clk);
            check("sb_rdata", d0_di, e.data);
          end
        end
      end
    end
  end

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
    wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic bus(input bit mreq, input bit iorq, input bit rd,
                     input bit wr, input bit m1, input bit rfsh,
                     input logic [15:0] a, input logic [7:0] d,
                     input int hold);
    @(negedge clk);
    cpu_a = a; cpu_do = d;
    mreq_n = !mreq; iorq_n = !iorq; rd_n = !rd;
    wr_n = !wr; m1_n = !m1; rfsh_n = !rfsh;
    repeat (hold) @(negedge clk);
    bus_idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    int r0, w0, wl0, r2, wl2, ior0, lat;
    logic [7:0] acc;
    reset = 1'b1; cpu_a = '0; cpu_do = '0;
    bus_idle();
    mem[16'h0000] = 8'hDD; mem[16'h0001] = 8'h8E;
    mem[16'h0002] = 8'h25; mem[16'hBBBC] = 8'h32;
    mem[16'h1234] = 8'hA5; iom[8'h20] = 8'h9B;
    repeat (3) @(negedge clk);
    check("rst_di", d0_di, 8'h00);
    check("rst_wait_n", d0_wait_n, 1);
    check("rst_strobes", {d0_mem_we, d0_mem_re, d0_io_we, d0_io_re}, 0);
    check("rst_addr", {d0_mem_addr, d0_io_addr}, 0);
    check("rst_wdata", {d0_mem_wdata, d0_io_wdata}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // ADC A,(IX+25h): DD 8E 25, operand at BB97+25 = BBBC
    r0 = d0_re_n; w0 = d0_we_n; wl0 = d0_wait_lo;
    push(0, 16'h0000, 8'hDD, 1);
    @(negedge clk);
    cpu_a = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (d0_di == 8'hDD) break;
    end
    check("latency_0wait", lat, 3);
    repeat (5) @(negedge clk);
    bus_idle();
    repeat (2) @(negedge clk);
    bus(1, 0, 0, 0, 0, 1, 16'h0000, 8'h00, 3);
    push(0, 16'h0001, 8'h8E, 1);
    bus(1, 0, 1, 0, 1, 0, 16'h0001, 8'h00, 8);
    bus(1, 0, 0, 0, 0, 1, 16'h0001, 8'h00, 3);
    push(0, 16'h0002, 8'h25, 1);
    bus(1, 0, 1, 0, 0, 0, 16'h0002, 8'h00, 8);
    push(0, 16'hBBBC, 8'h32, 1);
    bus(1, 0, 1, 0, 0, 0, 16'hBBBC, 8'h00, 8);
    check("insn_mem_re", d0_re_n - r0, 4);
    check("insn_mem_we", d0_we_n - w0, 0);
    check("insn_wait", d0_wait_lo - wl0, 0);
    acc = 8'h4E + d0_di;
    check("adc_result", acc, 8'h80);
`ifdef TV80_BUS_TRACE_EN
    check("trace_fetch", d0_fetch, 2);
`endif

    // Two-wait-state fetch
    r2 = w2_re_n; wl2 = w2_wait_lo;
    push(0, 16'h1234, 8'hA5, 1);
    bus(1, 0, 1, 0, 1, 0, 16'h1234, 8'h00, 8);
    check("w2_wait_cycles", w2_wait_lo - wl2, 2);
    check("w2_mem_re", w2_re_n - r2, 1);
    check("w2_di", w2_di, 8'hA5);

    // Memory write then read back
    push(1, 16'h4000, 8'h3C, 0);
    bus(1, 0, 0, 1, 0, 0, 16'h4000, 8'h3C, 8);
    push(0, 16'h4000, 8'h3C, 1);
    bus(1, 0, 1, 0, 0, 0, 16'h4000, 8'h00, 8);

    // OUT (7Fh),A with A=5C
    w0 = d0_we_n; wl0 = d0_wait_lo;
    push(3, 16'h007F, 8'h5C, 0);
    bus(0, 1, 0, 1, 0, 0, 16'h5C7F, 8'h5C, 8);
    check("out_mem_we", d0_we_n - w0, 0);
    check("out_io_wait", d0_wait_lo - wl0, 1);
`ifdef TV80_BUS_TRACE_EN
    check("trace_wr", d0_wrc, 2);
`endif

    // IN A,(20h)
    push(2, 16'h0020, 8'h9B, 1);
    bus(0, 1, 1, 0, 0, 0, 16'h4E20, 8'h00, 8);

    // Refresh: no strobe, read data held
    r0 = d0_re_n; w0 = d0_we_n;
    bus(1, 0, 0, 0, 0, 1, 16'h0055, 8'h00, 6);
    check("rfsh_strobes", (d0_re_n - r0) + (d0_we_n - w0), 0);
    check("rfsh_di_hold", d0_di, 8'h9B);

    // Interrupt acknowledge
    ior0 = d0_ior_n;
    bus(0, 1, 0, 0, 1, 0, 16'h0000, 8'h00, 6);
    check("intack_di", d0_di, 8'hFF);
    check("intack_io_re", d0_ior_n - ior0, 0);

    // Early release during wait states: no strobe on the waiting bridge
    r2 = w2_re_n;
    push(0, 16'h1234, 8'hA5, 0);
    bus(1, 0, 1, 0, 1, 0, 16'h1234, 8'h00, 1);
    check("abort_w2_re", w2_re_n - r2, 0);

    // Reset while in WAITST
    r2 = w2_re_n;
    push(0, 16'h1234, 8'hA5, 0);
    @(negedge clk);
    cpu_a = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0;
    @(negedge clk);
    check("rstw_in_wait", w2_wait_n, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rstw_wait_n", w2_wait_n, 1);
    check("rstw_strobes", {w2_mem_we, w2_mem_re, w2_io_we, w2_io_re}, 0);
    check("rstw_state", 32'(u_w2.state_q), 32'(IDLE));
`ifdef TV80_BUS_TRACE_EN
    check("rstw_fetch", w2_fetch, 0);
`endif
    bus_idle();
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rstw_no_re", w2_re_n - r2, 0);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
